// File: rtl/acc_host_pkg.sv
// Shared types and widths for the accelerator host: FSM states and bus geometry.
// Imported by acc_host and host_ram.
package acc_host_pkg;
    localparam int ADDR_W            = 16;
    localparam int DATA_W            = 32;
    localparam int DEFAULT_IMG_WORDS = 25344;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RUN     = 2'd1,
        DUMP_RD = 2'd2,
        DUMP_TX = 2'd3
    } state_t;
endpackage

// File: rtl/host_ram.sv
// Single-port image RAM: synchronous write, read data registered one cycle after re.
// No flow control; read data holds until the next read.
module host_ram
    import acc_host_pkg::*;
#(
    parameter int DEPTH = 2 * DEFAULT_IMG_WORDS
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  idx;
    logic              unused_addr;

    // Legal addresses always fit in IDX_W bits; upper bits are don't-care.
    assign idx         = addr[IDX_W-1:0];
    assign unused_addr = ^addr;
    assign rdata       = rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[idx];
        end
    end
endmodule

// File: rtl/acc_host.sv
// Accelerator host: streams an image into RAM, hands the RAM to the accelerator, streams the result out.
// Bus read data appears one cycle after the request; output stream holds under backpressure, one bubble per word.
module acc_host
    import acc_host_pkg::*;
#(
    parameter int IMG_WORDS = DEFAULT_IMG_WORDS,
    parameter int OUT_BASE  = 25344
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    input  logic              we,
    input  logic [DATA_W-1:0] dataW,
    output logic [DATA_W-1:0] dataR,
    output logic              start,
    input  logic              finish,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(IMG_WORDS - 1);
    localparam logic [ADDR_W-1:0] OUT_ADDR  = ADDR_W'(OUT_BASE);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   load_cnt_q, load_cnt_d;
    logic [ADDR_W-1:0]   dump_cnt_q, dump_cnt_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         asm_q, asm_d;
    logic                start_q, start_d;
    logic                out_valid_q, out_valid_d;
    logic                bus_rd_q, bus_rd_d;
    logic [DATA_W-1:0]   dataR_q, dataR_d;

    logic                ram_we, ram_re;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata, ram_rdata;

    host_ram #(.DEPTH(OUT_BASE + IMG_WORDS)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        dump_cnt_d  = dump_cnt_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        start_d     = start_q;
        out_valid_d = out_valid_q;
        bus_rd_d    = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = load_cnt_q;
        ram_wdata   = {in_data, asm_q};
        // dataR only tracks the RAM on the cycle after an accelerator read.
        dataR_d     = bus_rd_q ? ram_rdata : dataR_q;

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    asm_d      = {in_data, asm_q[23:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        ram_we     = 1'b1;
                        load_cnt_d = load_cnt_q + 1'b1;
                        if (load_cnt_q == LAST_WORD) begin
                            state_d = RUN;
                            start_d = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                ram_addr  = addr;
                ram_wdata = dataW;
                ram_we    = en & we;
                ram_re    = en & ~we;
                bus_rd_d  = en & ~we;
                if (finish) begin
                    start_d = 1'b0;
                    state_d = DUMP_RD;
                end
            end
            DUMP_RD: begin
                ram_addr    = OUT_ADDR + dump_cnt_q;
                ram_re      = 1'b1;
                out_valid_d = 1'b1;
                state_d     = DUMP_TX;
            end
            DUMP_TX: begin
                if (out_ready) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        out_valid_d = 1'b0;
                        if (dump_cnt_q == LAST_WORD) begin
                            state_d    = LOAD;
                            load_cnt_d = '0;
                            dump_cnt_d = '0;
                        end else begin
                            dump_cnt_d = dump_cnt_q + 1'b1;
                            state_d    = DUMP_RD;
                        end
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            load_cnt_q  <= '0;
            dump_cnt_q  <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            bus_rd_q    <= 1'b0;
            dataR_q     <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            dump_cnt_q  <= dump_cnt_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            start_q     <= start_d;
            out_valid_q <= out_valid_d;
            bus_rd_q    <= bus_rd_d;
            dataR_q     <= dataR_d;
        end
    end

    // The RAM read register holds the dump word for the whole of DUMP_TX.
    assign out_data  = out_valid_q ? ram_rdata[{byte_idx_q, 3'b000} +: 8] : 8'h00;
    assign out_valid = out_valid_q;
    assign start     = start_q;
    assign dataR     = dataR_d;
    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != LOAD);
endmodule
